// File: rtl/niosii_system_switch_debounced_if.sv
// Avalon-MM slave bus bundle for the debounced switch PIO.
interface niosii_system_switch_debounced_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/niosii_system_switch_debounced.sv
// Debounced switch/button input PIO: per-channel synchroniser and debounce counter,
// software-selectable edge capture and a masked, globally gated level interrupt.
module niosii_system_switch_debounced #(
  parameter int unsigned         WIDTH       = 8,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         DB_CNT_W    = 16,
  parameter logic [DB_CNT_W-1:0] DB_DEFAULT  = 16'd50000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [WIDTH-1:0]                       in_port,
  niosii_system_switch_debounced_if.slave        bus
);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrRaw    = 3'd1;
  localparam logic [2:0] AddrMask   = 3'd2;
  localparam logic [2:0] AddrCap    = 3'd3;
  localparam logic [2:0] AddrRiseEn = 3'd4;
  localparam logic [2:0] AddrFallEn = 3'd5;
  localparam logic [2:0] AddrLimit  = 3'd6;
  localparam logic [2:0] AddrCtrl   = 3'd7;

  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    raw_s;
  logic [WIDTH-1:0]    deb_q, deb_d;
  logic [WIDTH-1:0]    upd;
  logic [DB_CNT_W-1:0] cnt_q [WIDTH];
  logic [DB_CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]    mask_q, cap_q, cap_d, rise_en_q, fall_en_q;
  logic [WIDTH-1:0]    edge_ev, w1c;
  logic [DB_CNT_W-1:0] limit_q;
  logic                gie_q;
  logic [31:0]         rdata_d, rdata_q;
  logic                wr;

  assign wr    = bus.chipselect & ~bus.write_n;
  assign raw_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per-channel debounce: count a sustained mismatch, accept it once cnt reaches the limit.
  always_comb begin
    deb_d = deb_q;
    upd   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (raw_s[i] != deb_q[i]) begin
        if (cnt_q[i] >= limit_q) begin
          deb_d[i] = raw_s[i];
          upd[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  // Debounced state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Edge capture: new events are OR-ed in after the W1C clear, so an event beats a clear.
  always_comb begin
    edge_ev = upd & ((raw_s & rise_en_q) | (~raw_s & fall_en_q));
    w1c     = (wr && bus.address == AddrCap) ? bus.writedata[WIDTH-1:0] : '0;
    cap_d   = edge_ev | (cap_q & ~w1c);
  end

  // Software-visible control registers; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      cap_q     <= '0;
      rise_en_q <= '1;
      fall_en_q <= '1;
      limit_q   <= DB_DEFAULT;
      gie_q     <= 1'b0;
    end else begin
      cap_q <= cap_d;
      if (wr) begin
        case (bus.address)
          AddrMask:   mask_q    <= bus.writedata[WIDTH-1:0];
          AddrRiseEn: rise_en_q <= bus.writedata[WIDTH-1:0];
          AddrFallEn: fall_en_q <= bus.writedata[WIDTH-1:0];
          AddrLimit:  limit_q   <= bus.writedata[DB_CNT_W-1:0];
          AddrCtrl:   gie_q     <= bus.writedata[0];
          default: ;
        endcase
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rdata_d = '0;
    case (bus.address)
      AddrData:   rdata_d = 32'(deb_q);
      AddrRaw:    rdata_d = 32'(raw_s);
      AddrMask:   rdata_d = 32'(mask_q);
      AddrCap:    rdata_d = 32'(cap_q);
      AddrRiseEn: rdata_d = 32'(rise_en_q);
      AddrFallEn: rdata_d = 32'(fall_en_q);
      AddrLimit:  rdata_d = 32'(limit_q);
      AddrCtrl:   rdata_d = {31'd0, gie_q};
      default:    rdata_d = '0;
    endcase
  end

  // Registered read data, loaded every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign bus.readdata = rdata_q;
  assign bus.irq      = gie_q & |(cap_q & mask_q);

endmodule

// File: tb/tb_niosii_system_switch_debounced.sv
// Directed bench for the debounced switch PIO (WIDTH=8, SYNC_STAGES=2).
module tb_niosii_system_switch_debounced;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_port;
  int         checks   = 0;
  int         failures = 0;

  niosii_system_switch_debounced_if bus ();

  niosii_system_switch_debounced #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .DB_CNT_W   (16),
    .DB_DEFAULT (16'd50000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] exp_v [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'hFF, 32'd50000, 32'h0};
    logic [31:0] d;
    reset = 1'b1;
    tick(3);
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq: got %b expected 0", bus.irq);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      checks++;
      if (d !== exp_v[a]) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h expected %h", a, d, exp_v[a]);
      end
    end
  endtask

  task automatic test_setup();
    logic [31:0] d;
    bus_write(3'd6, 32'd4);
    bus_write(3'd2, 32'hFF);
    bus_write(3'd7, 32'h1);
    bus_read(3'd6, d);
    checks++;
    if (d !== 32'd4) begin
      failures++;
      $display("FAIL setup_limit: got %h expected %h", d, 32'd4);
    end
  endtask

  task automatic test_clean_rise();
    logic [31:0] d;
    bus.address = 3'd1;
    in_port[0] = 1'b1;
    tick(2);
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++;
      $display("FAIL rise_raw_early: got %h expected %h", bus.readdata, 32'h0);
    end
    tick();
    checks++;
    if (bus.readdata !== 32'h1) begin
      failures++;
      $display("FAIL rise_raw: got %h expected %h", bus.readdata, 32'h1);
    end
    tick(3);
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL rise_irq_early: got %b expected 0", bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++;
      $display("FAIL rise_irq: got %b expected 1", bus.irq);
    end
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL rise_cap: got %h expected %h", d, 32'h01);
    end
    bus_read(3'd0, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL rise_data: got %h expected %h", d, 32'h01);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic        seen = 1'b0;
    bus_write(3'd3, 32'hFF);
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL glitch_w1c_irq: got %b expected 0", bus.irq);
    end
    // Four cycles of raw_s mismatch with a limit of 4 must be discarded.
    in_port[3] = 1'b1;
    tick(4);
    in_port[3] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.irq !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL glitch_irq: got %b expected 0", seen);
    end
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_cap: got %h expected %h", d, 32'h0);
    end
    bus_read(3'd0, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL glitch_data: got %h expected %h", d, 32'h01);
    end
    // Six cycles pass the filter; the following fall is not captured with FALL_EN[3]=0.
    bus_write(3'd5, 32'hF7);
    in_port[3] = 1'b1;
    tick(6);
    in_port[3] = 1'b0;
    tick(15);
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h08) begin
      failures++;
      $display("FAIL pulse_cap: got %h expected %h", d, 32'h08);
    end
    bus_read(3'd0, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL pulse_data: got %h expected %h", d, 32'h01);
    end
    bus_write(3'd5, 32'hFF);
    bus_write(3'd3, 32'hFF);
  endtask

  task automatic test_edge_select();
    logic [31:0] d;
    bus_write(3'd4, 32'h00);
    bus_write(3'd5, 32'h04);
    in_port[2] = 1'b1;
    tick(10);
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL edgesel_after_rise: got %h expected %h", d, 32'h0);
    end
    in_port[2] = 1'b0;
    tick(10);
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h04) begin
      failures++;
      $display("FAIL edgesel_after_fall: got %h expected %h", d, 32'h04);
    end
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++;
      $display("FAIL edgesel_irq: got %b expected 1", bus.irq);
    end
    bus_write(3'd4, 32'hFF);
    bus_write(3'd5, 32'hFF);
    bus_write(3'd3, 32'hFF);
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    in_port[0] = 1'b0;
    tick(10);
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL race_pre_cap: got %h expected %h", d, 32'h01);
    end
    // deb[1] updates on the 7th edge after the pin change, same edge as the write.
    in_port[1] = 1'b1;
    tick(6);
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h02) begin
      failures++;
      $display("FAIL race_clear_other: got %h expected %h", d, 32'h02);
    end
    in_port[0] = 1'b1;
    tick(6);
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h03) begin
      failures++;
      $display("FAIL race_event_wins: got %h expected %h", d, 32'h03);
    end
    bus_write(3'd3, 32'h03);
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL race_w1c_irq: got %b expected 0", bus.irq);
    end
  endtask

  task automatic test_midflight();
    logic [31:0] d;
    logic [31:0] exp_v [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'hFF, 32'd50000, 32'h0};
    // Limit lowered to 0 while cnt[5]=3: update on the very next edge instead of after 10.
    bus_write(3'd6, 32'd10);
    in_port[5] = 1'b1;
    tick(5);
    bus_write(3'd6, 32'd0);
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL limit_irq_early: got %b expected 0", bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++;
      $display("FAIL limit_irq: got %b expected 1", bus.irq);
    end
    bus_read(3'd0, d);
    checks++;
    if (d !== 32'h23) begin
      failures++;
      $display("FAIL limit_data: got %h expected %h", d, 32'h23);
    end
    // Reset with a counter running, an irq pending and a competing CTRL write.
    bus_write(3'd6, 32'd4);
    in_port[6] = 1'b1;
    tick(4);
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre_irq: got %b expected 1", bus.irq);
    end
    reset          = 1'b1;
    in_port        = 8'h00;
    bus.address    = 3'd7;
    bus.writedata  = 32'h1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL midreset_irq: got %b expected 0", bus.irq);
    end
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++;
      $display("FAIL midreset_readdata: got %h expected %h", bus.readdata, 32'h0);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      checks++;
      if (d !== exp_v[a]) begin
        failures++;
        $display("FAIL midreset_reg%0d: got %h expected %h", a, d, exp_v[a]);
      end
    end
  endtask

  initial begin
    reset          = 1'b0;
    in_port        = 8'h00;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    test_reset();
    test_setup();
    test_clean_rise();
    test_glitch();
    test_edge_select();
    test_w1c_race();
    test_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
